// File: rtl/pwm_ramp_controller.sv
// Ramps a PWM duty word toward a target in fixed steps on PWM-period boundaries,
// and ramps it back to zero before dropping the generator enable.
module pwm_ramp_controller #(
  parameter int CLK_FREQ_c       = 100_000_000,
  parameter int PWM_FREQ_c       = 100,
  parameter int PWM_RESOLUTION_c = 10,
  parameter int STEP_PERIODS_c   = 1
) (
  input  logic                        CLK_i,
  input  logic                        RESET_n_i,
  input  logic                        START_i,
  input  logic [PWM_RESOLUTION_c-1:0] TARGET_i,
  input  logic [PWM_RESOLUTION_c-1:0] STEP_i,
  output logic                        EN_o,
  output logic [PWM_RESOLUTION_c-1:0] PWM_VALUE_o,
  output logic                        BUSY_o,
  output logic                        AT_TARGET_o
);
  localparam int R        = PWM_RESOLUTION_c;
  localparam int PERIOD_c = CLK_FREQ_c / PWM_FREQ_c;
  localparam int CNT_W    = (PERIOD_c > 1) ? $clog2(PERIOD_c) : 1;
  localparam int STP_W    = (STEP_PERIODS_c > 1) ? $clog2(STEP_PERIODS_c) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RAMP = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [STP_W-1:0] r_stp;
  logic [R-1:0]     r_val;
  logic             r_en, r_busy, r_at;

  logic             w_wrap, w_event;
  logic [R:0]       w_step_x, w_tgt_x, w_val_x;
  logic [R:0]       w_up_diff, w_dn_diff, w_sum, w_sub;
  logic [R-1:0]     w_sum_sat, w_sub_sat;
  logic [1:0]       w_nstate;
  logic [R-1:0]     w_nval;

  assign w_wrap  = (r_cnt == CNT_W'(PERIOD_c - 1));
  assign w_event = w_wrap && (r_stp == STP_W'(STEP_PERIODS_c - 1));

  // One extra bit on every intermediate so neither direction can wrap the duty word.
  assign w_step_x  = (STEP_i == '0) ? {{R{1'b0}}, 1'b1} : {1'b0, STEP_i};
  assign w_tgt_x   = {1'b0, TARGET_i};
  assign w_val_x   = {1'b0, r_val};
  assign w_up_diff = w_tgt_x - w_val_x;
  assign w_dn_diff = w_val_x - w_tgt_x;
  assign w_sum     = w_val_x + w_step_x;
  assign w_sub     = w_val_x - w_step_x;
  assign w_sum_sat = w_sum[R] ? {R{1'b1}} : w_sum[R-1:0];
  assign w_sub_sat = w_sub[R] ? {R{1'b0}} : w_sub[R-1:0];

  always_comb begin
    w_nstate = r_state;
    w_nval   = r_val;
    case (r_state)
      S_IDLE: begin
        w_nval = '0;
        if (START_i) w_nstate = S_RAMP;
      end
      S_RAMP: begin
        if (!START_i) begin
          w_nstate = S_STOP;
        end else if (w_event) begin
          if (TARGET_i == r_val) begin
            w_nstate = S_HOLD;
          end else if (TARGET_i > r_val) begin
            if (w_up_diff <= w_step_x) begin
              w_nval   = TARGET_i;
              w_nstate = S_HOLD;
            end else begin
              w_nval = w_sum_sat;
            end
          end else begin
            if (w_dn_diff <= w_step_x) begin
              w_nval   = TARGET_i;
              w_nstate = S_HOLD;
            end else begin
              w_nval = w_sub_sat;
            end
          end
        end
      end
      S_HOLD: begin
        if (!START_i)                           w_nstate = S_STOP;
        else if (w_event && TARGET_i != r_val)  w_nstate = S_RAMP;
      end
      default: begin
        if (START_i) begin
          w_nstate = S_RAMP;
        end else if (r_val == '0) begin
          w_nstate = S_IDLE;
        end else if (w_event) begin
          w_nval = w_sub_sat;
          if (w_sub_sat == '0) w_nstate = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_i or negedge RESET_n_i) begin
    if (!RESET_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stp   <= '0;
      r_val   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_at    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_val   <= w_nval;
      r_en    <= (w_nstate != S_IDLE);
      r_busy  <= (w_nstate == S_RAMP) || (w_nstate == S_STOP);
      r_at    <= (w_nstate == S_HOLD);
      // Counters stay aligned across RAMP/HOLD/STOP and only restart via IDLE.
      if (w_nstate == S_IDLE) begin
        r_cnt <= '0;
        r_stp <= '0;
      end else if (r_state != S_IDLE) begin
        if (w_wrap) begin
          r_cnt <= '0;
          r_stp <= w_event ? '0 : r_stp + STP_W'(1);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign EN_o        = r_en;
  assign PWM_VALUE_o = r_val;
  assign BUSY_o      = r_busy;
  assign AT_TARGET_o = r_at;
endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller: 10-clock PWM period, step event every 20 clocks.
module tb_pwm_ramp_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] tgt = '0;
  logic [9:0] stp = '0;
  logic       en, busy, at;
  logic [9:0] val;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    bit         start;
    logic [9:0] tgt;
    logic [9:0] stp;
    int         ncyc;
    logic [9:0] val;
    bit         en;
    bit         busy;
    bit         at;
  } vec_t;

  vec_t vecs[34];
  vec_t sb[$];

  always #5 clk = ~clk;

  pwm_ramp_controller #(
    .CLK_FREQ_c(1000), .PWM_FREQ_c(100), .PWM_RESOLUTION_c(10), .STEP_PERIODS_c(2)
  ) dut (
    .CLK_i(clk), .RESET_n_i(rst_n), .START_i(start), .TARGET_i(tgt), .STEP_i(stp),
    .EN_o(en), .PWM_VALUE_o(val), .BUSY_o(busy), .AT_TARGET_o(at)
  );

  function automatic vec_t mk(bit s, int t, int p, int n, int v, bit e, bit b, bit a);
    vec_t r;
    r.start = s; r.tgt = 10'(t); r.stp = 10'(p); r.ncyc = n;
    r.val = 10'(v); r.en = e; r.busy = b; r.at = a;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".en"}, 32'(en), 0);
    chk({tag, ".val"}, 32'(val), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".at"}, 32'(at), 0);
  endtask

  // Drive at a falling edge, then compare after ncyc rising edges.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    start = v.start; tgt = v.tgt; stp = v.stp;
    sb.push_back(v);
    repeat (v.ncyc) @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".val"}, 32'(val), 32'(e.val));
    chk({tag, ".en"}, 32'(en), 32'(e.en));
    chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
    chk({tag, ".at"}, 32'(at), 32'(e.at));
  endtask

  initial begin
    //            start tgt   stp   n   val   en busy at
    vecs[0]  = mk(1,   100,  30,   1,  0,    1, 1,   0);
    vecs[1]  = mk(1,   100,  30,   20, 30,   1, 1,   0);
    vecs[2]  = mk(1,   100,  30,   20, 60,   1, 1,   0);
    vecs[3]  = mk(1,   100,  30,   20, 90,   1, 1,   0);
    vecs[4]  = mk(1,   100,  30,   20, 100,  1, 0,   1);
    vecs[5]  = mk(1,   40,   30,   20, 100,  1, 1,   0);
    vecs[6]  = mk(1,   40,   30,   20, 70,   1, 1,   0);
    vecs[7]  = mk(1,   40,   30,   20, 40,   1, 0,   1);
    vecs[8]  = mk(1,   100,  30,   20, 40,   1, 1,   0);
    vecs[9]  = mk(1,   100,  30,   20, 70,   1, 1,   0);
    vecs[10] = mk(1,   100,  30,   20, 100,  1, 0,   1);
    vecs[11] = mk(0,   100,  30,   1,  100,  1, 1,   0);
    vecs[12] = mk(0,   100,  30,   19, 70,   1, 1,   0);
    vecs[13] = mk(0,   100,  30,   20, 40,   1, 1,   0);
    vecs[14] = mk(1,   100,  30,   1,  40,   1, 1,   0);
    vecs[15] = mk(1,   100,  30,   19, 70,   1, 1,   0);
    vecs[16] = mk(0,   100,  30,   1,  70,   1, 1,   0);
    vecs[17] = mk(0,   100,  30,   19, 40,   1, 1,   0);
    vecs[18] = mk(0,   100,  30,   20, 10,   1, 1,   0);
    vecs[19] = mk(0,   100,  30,   20, 0,    0, 0,   0);
    vecs[20] = mk(1,   3,    0,    1,  0,    1, 1,   0);
    vecs[21] = mk(1,   3,    0,    20, 1,    1, 1,   0);
    vecs[22] = mk(1,   3,    0,    20, 2,    1, 1,   0);
    vecs[23] = mk(1,   3,    0,    20, 3,    1, 0,   1);
    vecs[24] = mk(1,   1000, 1023, 20, 3,    1, 1,   0);
    vecs[25] = mk(1,   1000, 1023, 20, 1000, 1, 0,   1);
    vecs[26] = mk(1,   1023, 30,   20, 1000, 1, 1,   0);
    vecs[27] = mk(1,   1023, 30,   20, 1023, 1, 0,   1);
    vecs[28] = mk(1,   0,    1000, 20, 1023, 1, 1,   0);
    vecs[29] = mk(1,   0,    1000, 20, 23,   1, 1,   0);
    vecs[30] = mk(1,   0,    1000, 20, 0,    1, 0,   1);
    vecs[31] = mk(1,   1023, 1000, 20, 0,    1, 1,   0);
    vecs[32] = mk(1,   1023, 1000, 20, 1000, 1, 1,   0);
    vecs[33] = mk(1,   1023, 1000, 20, 1023, 1, 0,   1);

    #3;
    chk_idle("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_idle("post_release");

    foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i));

    // Async reset mid-ramp at value 60.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply(mk(1, 100, 30, 1,  0,  1, 1, 0), "rr_entry");
    apply(mk(1, 100, 30, 20, 30, 1, 1, 0), "rr_30");
    apply(mk(1, 100, 30, 20, 60, 1, 1, 0), "rr_60");
    #2 rst_n = 1'b0;
    #1 chk_idle("async_reset");
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk_idle("idle_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_controller.md
PWM_RAMP_CONTROLLER -- requirements
Module: pwm_ramp_controller

Interface
REQ-001 Parameter CLK_FREQ_c, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter PWM_FREQ_c, default 100, PWM frequency in Hz; PERIOD_c = CLK_FREQ_c/PWM_FREQ_c clocks.
REQ-003 Parameter PWM_RESOLUTION_c, default 10, duty word width in bits (R).
REQ-004 Parameter STEP_PERIODS_c, default 1, number of PWM periods between duty steps (>=1).
REQ-005 CLK_i  in  1  single system clock; all state on rising edge.
REQ-006 RESET_n_i  in  1  asynchronous, active-low reset.
REQ-007 START_i  in  1  level run request; 1 = ramp up and run, 0 = ramp down and stop.
REQ-008 TARGET_i  in  R  requested duty value.
REQ-009 STEP_i  in  R  duty increment per step event; 0 SHALL be treated as 1.
REQ-010 EN_o  out  1  enable to pwm_generator EN_i.
REQ-011 PWM_VALUE_o  out  R  duty to pwm_generator PWM_VALUE_i.
REQ-012 BUSY_o  out  1  high in RAMP or STOP state.
REQ-013 AT_TARGET_o  out  1  high in HOLD state.

Function
REQ-014 States SHALL be IDLE, RAMP, HOLD, STOP; all outputs registered.
REQ-015 Period counter SHALL count 0..PERIOD_c-1 and wrap while state != IDLE; held at 0 in IDLE; step counter counts wraps 0..STEP_PERIODS_c-1.
REQ-016 Step event SHALL be the cycle the period counter wraps with step counter = STEP_PERIODS_c-1; first step event is STEP_PERIODS_c*PERIOD_c clocks after leaving IDLE, then every STEP_PERIODS_c*PERIOD_c clocks.
REQ-017 IDLE: EN_o=0, PWM_VALUE_o=0; START_i=1 -> RAMP, EN_o=1 on the next edge.
REQ-018 RAMP: at each step event TARGET_i SHALL be sampled; value moves toward it by STEP_i; if |TARGET_i - value| <= STEP_i value := TARGET_i.
REQ-019 RAMP: when the new value equals the sampled target (or value already equals it at a step event) -> HOLD on the same edge.
REQ-020 Arithmetic SHALL use R+1-bit intermediates; PWM_VALUE_o never wraps past 2^R-1 or below 0.
REQ-021 HOLD: at a step event with TARGET_i != PWM_VALUE_o -> RAMP (no value change on that event).
REQ-022 RAMP or HOLD with START_i=0 on any cycle -> STOP on next edge; value unchanged on that edge.
REQ-023 STOP: at each step event value := max(value - STEP_i, 0); when value is 0 (including on entry) -> IDLE, EN_o=0 and counters cleared on that edge.
REQ-024 STOP with START_i=1 -> RAMP on next edge; value and counters not reset.
REQ-025 EN_o SHALL be 1 in RAMP, HOLD, STOP; PWM_VALUE_o SHALL change only on step events or reset.

Reset
REQ-026 RESET_n_i=0 SHALL immediately force state IDLE, EN_o=0, PWM_VALUE_o=0, BUSY_o=0, AT_TARGET_o=0, counters 0, regardless of current state.
REQ-027 After release, block SHALL remain IDLE until START_i=1 is sampled.

Verification (CLK_FREQ_c=1000, PWM_FREQ_c=100, STEP_PERIODS_c=2 -> step every 20 clocks, R=10)
REQ-028 Reset asserted mid-RAMP at value 60 -> all outputs 0 without waiting for a clock edge; stays IDLE after release with START_i=0.
REQ-029 START_i=1, TARGET_i=100, STEP_i=30 -> EN_o=1 one clock later; PWM_VALUE_o 30,60,90,100 at clocks 20,40,60,80 after RAMP entry; AT_TARGET_o=1, BUSY_o=0 with 100.
REQ-030 In HOLD at 100, TARGET_i=40 -> next step event enters RAMP, following events give 70 then 40 with HOLD.
REQ-031 In HOLD at 100, START_i=0, STEP_i=30 -> STOP; values 70,40,10,0 at successive step events; EN_o=0 and IDLE on the edge value reaches 0.
REQ-032 STEP_i=0, TARGET_i=3 -> values 1,2,3; then TARGET_i=1023, STEP_i=30 from 1000 -> 1023 in one step, no overflow.
REQ-033 START_i toggled 0 then 1 during STOP at value 40 -> RAMP resumes from 40 toward TARGET_i without passing through IDLE.
